// File: rtl/spike_event_collector.sv
// Spike event collector: captures per-neuron spike strobes into a pending
// bitmap, picks one pending neuron per cycle with a round-robin arbiter and
// presents it as a valid/ready event tagged with the current timestep.
// Spikes that arrive while their neuron is still pending are dropped and
// counted in a saturating counter with a sticky overflow flag.
module spike_event_collector #(
  parameter int NUM_NEURONS = 16,
  parameter int NEURON_ID_W = 4,
  parameter int TS_W        = 8,
  parameter int DROP_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   scan_start_en,
  input  logic [NUM_NEURONS-1:0] lif_spike,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NEURON_ID_W-1:0] out_neuron,
  output logic [TS_W-1:0]        out_timestep,
  output logic                   busy,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt
);

  localparam int SUM_W = DROP_W + NEURON_ID_W + 1;

  logic [NUM_NEURONS-1:0] pending_q, pending_d;
  logic                   out_valid_q, out_valid_d;
  logic [NEURON_ID_W-1:0] out_neuron_q, out_neuron_d;
  logic [TS_W-1:0]        out_timestep_q, out_timestep_d;
  logic [TS_W-1:0]        timestep_q, timestep_d;
  logic [NEURON_ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic                   overflow_q, overflow_d;
  logic [DROP_W-1:0]      drop_cnt_q, drop_cnt_d;

  logic [NEURON_ID_W-1:0] hi_idx, lo_idx, grant_idx;
  logic                   hi_found;
  logic                   any_pend, load_ok, do_grant;
  logic [NUM_NEURONS-1:0] clr, drop_vec, pending_cap;
  logic [NEURON_ID_W:0]   drop_num;
  logic [SUM_W-1:0]       drop_sum;

  // Round-robin search: first pending bit at or above rr_ptr, else lowest pending bit.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        lo_idx = NEURON_ID_W'(i);
        if (NEURON_ID_W'(i) >= rr_ptr_q) begin
          hi_idx   = NEURON_ID_W'(i);
          hi_found = 1'b1;
        end
      end
    end
  end

  assign grant_idx = hi_found ? hi_idx : lo_idx;
  assign any_pend  = |pending_q;
  assign load_ok   = !out_valid_q || out_ready;
  assign do_grant  = load_ok && any_pend;

  // Per-neuron clear, drop detection and pending capture.
  generate
    for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_bit
      assign clr[gi]         = do_grant && (grant_idx == NEURON_ID_W'(gi));
      assign drop_vec[gi]    = lif_spike[gi] && pending_q[gi] && !clr[gi];
      assign pending_cap[gi] = (pending_q[gi] && !clr[gi]) || lif_spike[gi];
    end
  endgenerate

  // Number of spikes dropped this cycle and the saturating running total.
  always_comb begin
    drop_num = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      drop_num = drop_num + (NEURON_ID_W + 1)'(drop_vec[i]);
    end
    drop_sum = SUM_W'(drop_cnt_q) + SUM_W'(drop_num);
  end

  // Next-state: timestep boundary clears everything, otherwise arbitrate and capture.
  always_comb begin
    pending_d      = pending_q;
    out_valid_d    = out_valid_q;
    out_neuron_d   = out_neuron_q;
    out_timestep_d = out_timestep_q;
    timestep_d     = timestep_q;
    rr_ptr_d       = rr_ptr_q;
    overflow_d     = overflow_q;
    drop_cnt_d     = drop_cnt_q;
    if (scan_start_en) begin
      pending_d    = '0;
      out_valid_d  = 1'b0;
      out_neuron_d = '0;
      rr_ptr_d     = '0;
      overflow_d   = 1'b0;
      drop_cnt_d   = '0;
      timestep_d   = timestep_q + TS_W'(1);
    end else begin
      pending_d = pending_cap;
      if (load_ok) begin
        if (any_pend) begin
          out_valid_d    = 1'b1;
          out_neuron_d   = grant_idx;
          out_timestep_d = timestep_q;
          rr_ptr_d       = grant_idx + NEURON_ID_W'(1);
        end else begin
          out_valid_d = 1'b0;
        end
      end
      if (|drop_vec) begin
        overflow_d = 1'b1;
        if (drop_sum > SUM_W'({DROP_W{1'b1}})) begin
          drop_cnt_d = {DROP_W{1'b1}};
        end else begin
          drop_cnt_d = drop_sum[DROP_W-1:0];
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q      <= '0;
      out_valid_q    <= 1'b0;
      out_neuron_q   <= '0;
      out_timestep_q <= '0;
      timestep_q     <= '0;
      rr_ptr_q       <= '0;
      overflow_q     <= 1'b0;
      drop_cnt_q     <= '0;
    end else begin
      pending_q      <= pending_d;
      out_valid_q    <= out_valid_d;
      out_neuron_q   <= out_neuron_d;
      out_timestep_q <= out_timestep_d;
      timestep_q     <= timestep_d;
      rr_ptr_q       <= rr_ptr_d;
      overflow_q     <= overflow_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_neuron   = out_neuron_q;
  assign out_timestep = out_timestep_q;
  assign overflow     = overflow_q;
  assign drop_cnt     = drop_cnt_q;
  assign busy         = any_pend || out_valid_q;

endmodule
